// File: rtl/deci_to_bin_encoder.sv
// Registered 10-line decimal to 4-bit BCD encoder with legality flags and a
// saturating count of illegal samples. PRIORITY selects one-hot or highest-bit decode.
module deci_to_bin_encoder #(
    parameter int PRIORITY = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [9:0] D,
    output logic [3:0] Y,
    output logic       valid,
    output logic       err,
    output logic [7:0] err_cnt
);

    // Index of the most significant asserted line; 0 when no line is set.
    function automatic logic [3:0] highest_index(input logic [9:0] d);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (d[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Exactly one line set: clearing the lowest set bit leaves nothing.
    function automatic logic is_one_hot(input logic [9:0] d);
        return (d != 10'd0) && ((d & (d - 10'd1)) == 10'd0);
    endfunction

    localparam logic PRIO_EN = (PRIORITY != 32'sd0);

    logic [3:0] code_s;
    logic       valid_s;
    logic       err_s;

    logic [3:0] y_r;
    logic       valid_r;
    logic       err_r;
    logic [7:0] err_cnt_r;

    // Classify the current sample and pick its code.
    always_comb begin
        code_s  = 4'd0;
        valid_s = 1'b0;
        err_s   = 1'b0;
        if (D == 10'd0) begin
            err_s = 1'b1;
        end else if (is_one_hot(D) || PRIO_EN) begin
            code_s  = highest_index(D);
            valid_s = 1'b1;
        end else begin
            err_s = 1'b1;
        end
    end

    // Output and error-counter registers; reset wins over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_r       <= 4'd0;
            valid_r   <= 1'b0;
            err_r     <= 1'b0;
            err_cnt_r <= 8'd0;
        end else if (en) begin
            y_r     <= code_s;
            valid_r <= valid_s;
            err_r   <= err_s;
            if (err_s && (err_cnt_r != 8'd255)) begin
                err_cnt_r <= err_cnt_r + 8'd1;
            end else begin
                err_cnt_r <= err_cnt_r;
            end
        end else begin
            y_r       <= y_r;
            valid_r   <= valid_r;
            err_r     <= err_r;
            err_cnt_r <= err_cnt_r;
        end
    end

    assign Y       = y_r;
    assign valid   = valid_r;
    assign err     = err_r;
    assign err_cnt = err_cnt_r;

endmodule

// File: tb/tb_deci_to_bin_encoder.sv
// Scoreboard bench for deci_to_bin_encoder: one instance per PRIORITY value,
// expectations from a line-counting reference model, checked by a monitor at negedge.
module tb_deci_to_bin_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [9:0] D;

    logic [3:0] y0, y1;
    logic       v0, v1, e0, e1;
    logic [7:0] c0, c1;

    always #5 clk = ~clk;

    deci_to_bin_encoder #(.PRIORITY(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .D(D),
        .Y(y0), .valid(v0), .err(e0), .err_cnt(c0)
    );

    deci_to_bin_encoder #(.PRIORITY(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .D(D),
        .Y(y1), .valid(v1), .err(e1), .err_cnt(c1)
    );

    typedef struct {
        int y;
        int valid;
        int err;
        int cnt;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t m0 = '{0, 0, 0, 0};
    exp_t m1 = '{0, 0, 0, 0};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference: count asserted lines, find the top one, apply the decode rules.
    function automatic exp_t model_next(input exp_t s, input logic r, input logic e,
                                        input logic [9:0] d, input int prio);
        exp_t n;
        int ones;
        int hi;
        n = s;
        if (r) begin
            n = '{0, 0, 0, 0};
        end else if (e) begin
            ones = 0;
            hi = 0;
            for (int i = 0; i < 10; i++) begin
                if (d[i]) begin
                    ones++;
                    hi = i;
                end
            end
            if (ones == 1 || (ones > 1 && prio == 1)) begin
                n.y = hi; n.valid = 1; n.err = 0;
            end else begin
                n.y = 0; n.valid = 0; n.err = 1;
                n.cnt = (s.cnt >= 255) ? 255 : s.cnt + 1;
            end
        end
        return n;
    endfunction

    task automatic step(input logic r, input logic e, input logic [9:0] d);
        rst = r;
        en  = e;
        D   = d;
        m0 = model_next(m0, r, e, d, 0);
        m1 = model_next(m1, r, e, d, 1);
        @(posedge clk);
        #1;
        q0.push_back(m0);
        q1.push_back(m1);
    endtask

    // Park the inputs and wait (bounded) for the monitor to consume every expectation.
    task automatic drain(input string tag);
        rst = 1'b0;
        en  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            @(posedge clk);
        end
        check({tag, " queue drained"}, q0.size() + q1.size(), 0);
    endtask

    // Monitor: outputs settle after the posedge, compared on the falling edge.
    always @(negedge clk) begin : monitor
        exp_t x;
        if (q0.size() > 0) begin
            x = q0.pop_front();
            check("p0 Y", int'(y0), x.y);
            check("p0 valid", int'(v0), x.valid);
            check("p0 err", int'(e0), x.err);
            check("p0 err_cnt", int'(c0), x.cnt);
        end
        if (q1.size() > 0) begin
            x = q1.pop_front();
            check("p1 Y", int'(y1), x.y);
            check("p1 valid", int'(v1), x.valid);
            check("p1 err", int'(e1), x.err);
            check("p1 err_cnt", int'(c1), x.cnt);
        end
    end

    initial begin
        logic [9:0] rd;
        rst = 1'b1;
        en  = 1'b1;
        D   = 10'h3FF;
        @(posedge clk);
        #1;

        step(1'b1, 1'b1, 10'h3FF);
        step(1'b1, 1'b1, 10'h3FF);

        for (int i = 0; i < 10; i++) begin
            rd = 10'd1 << i;
            step(1'b0, 1'b1, rd);
        end

        step(1'b0, 1'b1, 10'b0000000000);
        step(1'b0, 1'b1, 10'b0100000100);

        step(1'b0, 1'b1, 10'b0000100000);
        repeat (3) step(1'b0, 1'b0, 10'b0000000000);

        // Mid-stream reset discards the sample presented with it.
        step(1'b0, 1'b1, 10'b1000000000);
        step(1'b1, 1'b1, 10'b0000000011);
        step(1'b0, 1'b1, 10'b0000001000);

        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 3))
                0: rd = 10'd1 << $urandom_range(0, 9);
                1: rd = 10'd0;
                default: rd = 10'($urandom);
            endcase
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) != 0), rd);
        end

        step(1'b1, 1'b0, 10'd0);
        for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 10'd0);
        drain("saturation");
        check("sat p0 err_cnt", int'(c0), 255);
        check("sat p1 err_cnt", int'(c1), 255);

        step(1'b1, 1'b1, 10'd0);
        step(1'b0, 1'b1, 10'b0000000100);
        drain("final");
        check("final p0 err_cnt", int'(c0), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
